uart_op_sequencer: RTL and testbench

Control FSM between the UART receiver, the arithmetic core and the UART transmitter in the accelerator top level. It collects two operand bytes from the host over UART and launches one core operation. It then returns the core's result byte to the host and reports sequencing status on LED-style flags. All handshakes are single-cycle pulses on `clk`.

---
 rtl/uart_op_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_uart_op_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_op_sequencer.sv
// Sequencer between the UART receiver, the arithmetic core and the UART transmitter.
// Optional inter-byte timeout in S_WAIT_B is enabled by defining SEQ_TIMEOUT_EN.
module uart_op_sequencer #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_en,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              core_start,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy,
  output logic              result_sent,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_B = 3'd1,
    S_START  = 3'd2,
    S_CORE   = 3'd3,
    S_SEND   = 3'd4,
    S_TX     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_cap_a;
  logic                w_cap_b;
  logic                w_cap_res;
  logic                w_set_sent;
  logic                w_timeout;
  logic                w_expired;
  logic                w_drop;

  logic                r_rx_en;
  logic                r_tx_start;
  logic [DATA_W-1:0]   r_tx_data;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic                r_core_start;
  logic                r_busy;
  logic                r_result_sent;
  logic                r_err_timeout;
  logic [CNT_W-1:0]    r_drop_cnt;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  // Counter is held at zero outside S_WAIT_B, so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state != S_WAIT_B) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  assign w_expired = (r_tmo_cnt == TMO_LAST);
`else
  assign w_expired = 1'b0;
`endif

  // Bytes arriving after the operands are captured and before the reply is sent are discarded.
  assign w_drop = rx_done && (r_state == S_START || r_state == S_CORE ||
                              r_state == S_SEND  || r_state == S_TX);

  always_comb begin
    w_state_nxt = r_state;
    w_cap_a     = 1'b0;
    w_cap_b     = 1'b0;
    w_cap_res   = 1'b0;
    w_set_sent  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_done) begin
          w_cap_a     = 1'b1;
          w_state_nxt = S_WAIT_B;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_B: begin
        // A byte on the expiry cycle still counts as operand B.
        if (rx_done) begin
          w_cap_b     = 1'b1;
          w_state_nxt = S_START;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_B;
        end
      end
      S_START: w_state_nxt = S_CORE;
      S_CORE: begin
        if (core_done) begin
          w_cap_res   = 1'b1;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_CORE;
        end
      end
      S_SEND: w_state_nxt = S_TX;
      S_TX: begin
        if (tx_done) begin
          w_set_sent  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_TX;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulses and busy are derived from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rx_en       <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_op_a        <= '0;
      r_op_b        <= '0;
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_result_sent <= 1'b0;
      r_err_timeout <= 1'b0;
      r_drop_cnt    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_en      <= 1'b1;
      r_core_start <= (w_state_nxt == S_START);
      r_tx_start   <= (w_state_nxt == S_SEND);
      r_busy       <= (w_state_nxt != S_IDLE);
      if (w_cap_a) begin
        r_op_a <= rx_data;
      end else if (w_timeout) begin
        r_op_a <= '0;
      end
      if (w_cap_b) begin
        r_op_b <= rx_data;
      end
      if (w_cap_res) begin
        r_tx_data <= core_result;
      end
      if (w_set_sent) begin
        r_result_sent <= 1'b1;
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign rx_en       = r_rx_en;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign op_a        = r_op_a;
  assign op_b        = r_op_b;
  assign core_start  = r_core_start;
  assign busy        = r_busy;
  assign result_sent = r_result_sent;
  assign err_timeout = r_err_timeout;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_uart_op_sequencer.sv
// Scoreboard bench for uart_op_sequencer: the bench plays host, core and transmitter.
module tb_uart_op_sequencer;

  localparam int DW  = 8;
  localparam int CW  = 3;
  localparam int TMO = 100;
  localparam int DROP_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          rx_en;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_done = 1'b0;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic          busy;
  logic          result_sent;
  logic          err_timeout;
  logic [CW-1:0] drop_cnt;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_drop = 0;

  uart_op_sequencer #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_en(rx_en),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .op_a(op_a), .op_b(op_b),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .busy(busy), .result_sent(result_sent), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drives one rx_done pulse; a byte sent while busy is expected to be counted as dropped.
  task automatic send_byte(input logic [DW-1:0] d, input bit dropped);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = d;
    @(negedge clk);
    rx_done = 1'b0;
    if (dropped && exp_drop < DROP_MAX) exp_drop++;
  endtask

  task automatic start_txn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    txn_t t;
    t.a = a;
    t.b = b;
    t.res = a + b;
    sb.push_back(t);
    send_byte(a, 1'b0);
    chk("busy_wait_b", busy, 1);
    chk("op_a_capture", op_a, a);
    chk("no_early_core_start", core_start, 0);
    send_byte(b, 1'b0);
    chk("core_start_pulse", core_start, 1);
    chk("op_a_at_start", op_a, sb[0].a);
    chk("op_b_at_start", op_b, sb[0].b);
    @(negedge clk);
    chk("core_start_one_cycle", core_start, 0);
    chk("busy_core", busy, 1);
  endtask

  task automatic finish_core(input bit with_rx);
    @(negedge clk);
    core_done = 1'b1;
    core_result = sb[0].res;
    if (with_rx) begin
      rx_done = 1'b1;
      rx_data = 8'hEE;
    end
    @(negedge clk);
    core_done = 1'b0;
    rx_done = 1'b0;
    if (with_rx && exp_drop < DROP_MAX) exp_drop++;
    chk("tx_start_pulse", tx_start, 1);
    chk("tx_data_result", tx_data, sb[0].res);
    chk("drop_cnt_core", drop_cnt, exp_drop);
    @(negedge clk);
    chk("tx_start_one_cycle", tx_start, 0);
  endtask

  task automatic finish_tx();
    txn_t t;
    t = sb.pop_front();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("result_sent", result_sent, 1);
    chk("idle_after_tx", busy, 0);
    chk("tx_data_held", tx_data, t.res);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {result_sent, err_timeout, tx_start, core_start}, 0);
    chk("rst_data", {op_a, op_b, tx_data}, 0);
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rx_en_after_release", rx_en, 1);

    // Normal transaction
    start_txn(8'd5, 8'd7);
    chk("result_sent_before_tx", result_sent, 0);
    finish_core(1'b0);
    finish_tx();

    // Spurious core_done in S_IDLE, spurious tx_done in S_WAIT_B
    @(negedge clk);
    core_done = 1'b1;
    core_result = 8'h99;
    @(negedge clk);
    core_done = 1'b0;
    chk("spur_core_busy", busy, 0);
    chk("spur_core_tx_start", tx_start, 0);
    chk("spur_core_tx_data", tx_data, 12);
    send_byte(8'd3, 1'b0);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("spur_tx_busy", busy, 1);
    chk("spur_tx_no_start", {core_start, tx_start}, 0);
    chk("spur_tx_op_a", op_a, 3);
    chk("err_timeout_clear", err_timeout, 0);
    sb.push_back('{a: 8'd3, b: 8'd4, res: 8'd7});
    send_byte(8'd4, 1'b0);
    chk("spur_core_start", core_start, 1);
    chk("spur_op_b", op_b, sb[0].b);
    @(negedge clk);
    finish_core(1'b0);
    finish_tx();

    // Busy drop: three bytes while in S_CORE
    start_txn(8'd10, 8'd20);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    chk("drop_cnt_three", drop_cnt, exp_drop);
    chk("drop_op_a", op_a, 10);
    chk("drop_op_b", op_b, 20);
    finish_core(1'b0);
    finish_tx();

    // Simultaneous rx_done and core_done in S_CORE
    start_txn(8'd1, 8'd2);
    finish_core(1'b1);
    chk("simul_busy", busy, 1);
    finish_tx();

    // Reset in S_TX
    start_txn(8'd6, 8'd6);
    finish_core(1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rx_en", rx_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", {op_a, op_b, tx_data}, 0);
    chk("mid_rst_flags", {result_sent, err_timeout, tx_start, core_start}, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    reset = 1'b1;
    sb.delete();
    exp_drop = 0;
    @(negedge clk);
    chk("post_rst_pulses", {tx_start, core_start, busy}, 0);
    start_txn(8'd9, 8'd4);
    finish_core(1'b0);
    finish_tx();

    // Drop counter saturation
    start_txn(8'd2, 8'd3);
    for (int i = 0; i < DROP_MAX + 2; i++) send_byte(8'h55, 1'b1);
    chk("drop_saturated", drop_cnt, exp_drop);
    finish_core(1'b0);
    finish_tx();

`ifdef SEQ_TIMEOUT_EN
    // Timeout in S_WAIT_B
    send_byte(8'd5, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_not_yet", {busy, err_timeout}, 2'b10);
    @(negedge clk);
    chk("tmo_idle", busy, 0);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_op_a_cleared", op_a, 0);
    start_txn(8'd1, 8'd2);
    finish_core(1'b0);
    finish_tx();
`else
    // Without the timeout, S_WAIT_B waits indefinitely
    send_byte(8'd5, 1'b0);
    repeat (TMO + 20) @(negedge clk);
    chk("no_tmo_busy", busy, 1);
    chk("no_tmo_err", err_timeout, 0);
    chk("no_tmo_op_a", op_a, 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
